pulse_code_seq: RTL and testbench
=================================

PULSE_CODE_SEQ -- requirements
Module: pulse_code_seq

Interface
REQ-001 SHALL have parameter CODE_MAX, default 32, giving the maximum chips per code (CODE_A/CODE_B width).
REQ-002 SHALL have parameter CHIP_W, default 16, giving the CHIP_LEN and chip counter width.
REQ-003 SHALL have parameter REP_W, default 16, giving the REP_NUM and PULSE_IDX width.
REQ-004 SHALL have port CLOCK_10M, input, 1 bit: the only clock; all logic on its rising edge.
REQ-005 SHALL have port RESET, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port START, input, 1 bit: single-cycle request to begin a pulse train.
REQ-007 SHALL have port ABORT, input, 1 bit: single-cycle request to terminate the train.
REQ-008 SHALL have ports CODE_A and CODE_B, input, CODE_MAX bits each: phase codes, chip 0 = bit 0.
REQ-009 SHALL have port ALT_EN, input, 1 bit: when 1, even pulses use CODE_A and odd pulses use CODE_B (complementary pair).
REQ-010 SHALL have port CODE_NUM, input, 8 bits: coded chips per pulse.
REQ-011 SHALL have port PULSE_NUM, input, 16 bits: total chips per pulse period (code plus blank).
REQ-012 SHALL have port REP_NUM, input, REP_W bits: number of pulse periods in the train.
REQ-013 SHALL have port CHIP_LEN, input, CHIP_W bits: clock cycles per chip.
REQ-014 SHALL have port MA, output, 1 bit: amplitude gate, 1 during coded chips.
REQ-015 SHALL have port MP, output, 1 bit: phase bit for the current chip.
REQ-016 SHALL have port PRF_TICK, output, 1 bit: one-cycle strobe at the first cycle of each pulse period.
REQ-017 SHALL have port BUSY, output, 1 bit: high while a train runs.
REQ-018 SHALL have port GEN_OVER, output, 1 bit: high when idle after completion, abort or reset; low while BUSY.
REQ-019 SHALL have port CFG_ERR, output, 1 bit: one-cycle strobe on a rejected START.
REQ-020 SHALL have port PULSE_IDX, output, REP_W bits: index of the current pulse period.

Function
REQ-021 SHALL register all outputs.
REQ-022 SHALL implement states IDLE, RUN_CODE, RUN_BLANK.
REQ-023 SHALL, on START in IDLE, latch CODE_A, CODE_B, ALT_EN, CODE_NUM, PULSE_NUM, REP_NUM and CHIP_LEN; later input changes SHALL have no effect until the next START.
REQ-024 SHALL clamp the effective code length to min(CODE_NUM, CODE_MAX), and SHALL take the effective period as max(PULSE_NUM, effective code length).
REQ-025 SHALL reject START when CHIP_LEN=0, REP_NUM=0 or effective period=0, pulsing CFG_ERR for one cycle the next cycle and remaining in IDLE with GEN_OVER=1.
REQ-026 SHALL, on an accepted START, assert BUSY=1, GEN_OVER=0, PRF_TICK=1 and PULSE_IDX=0 in the next cycle, which is also the first cycle of chip 0.
REQ-027 SHALL hold every chip for exactly CHIP_LEN cycles.
REQ-028 SHALL, in RUN_CODE, drive MA=1 and MP=selected code bit[chip index] during chip indices below the effective code length.
REQ-029 SHALL, in RUN_BLANK, drive MA=0 and MP=0 for the remaining chips of the period.
REQ-030 SHALL drive MP=0 whenever MA=0.
REQ-031 SHALL go directly to RUN_BLANK at period start when the effective code length is 0.
REQ-032 SHALL, after the last chip of a period, increment PULSE_IDX and pulse PRF_TICK with no gap cycle if PULSE_IDX is below REP_NUM-1.
REQ-033 SHALL otherwise enter IDLE with MA=0, BUSY=0 and GEN_OVER=1 on the cycle after the last chip.
REQ-034 SHALL total exactly REP_NUM × period × CHIP_LEN cycles from the first chip to GEN_OVER=1.
REQ-035 SHALL ignore START while BUSY.
REQ-036 SHALL, on ABORT in any state, drive MA=0, MP=0, BUSY=0, GEN_OVER=1 and IDLE next cycle.
REQ-037 SHALL give ABORT priority over a simultaneous START, so no train starts.
REQ-038 SHALL hold PULSE_IDX at its last value in IDLE.

Reset
REQ-039 SHALL, with RESET=1 at a clock edge, enter IDLE with MA=0, MP=0, PRF_TICK=0, BUSY=0, CFG_ERR=0, PULSE_IDX=0, GEN_OVER=1 and all latched configuration cleared.
REQ-040 SHALL give RESET priority over START and ABORT, and SHALL use it to terminate a running train immediately.

Structure
REQ-041 SHALL place the state enumeration and the parameter defaults (CODE_MAX, CHIP_W, REP_W) in shared package pulse_code_pkg.
REQ-042 SHALL implement the chip timer in one sub-module, chip_timer: a loadable down-counter giving a last-cycle strobe, reset by RESET and ABORT.

Verification
REQ-043 SHALL verify nominal operation: CODE_A=0xBD1B, CODE_NUM=16, PULSE_NUM=320, REP_NUM=1, CHIP_LEN=256 -> MA high for 4096 cycles, MP follows 0xBD1B LSB-first per 256 cycles, GEN_OVER rises 81920 cycles after the first chip.
REQ-044 SHALL verify alternation: ALT_EN=1, CODE_A=0x3, CODE_B=0x1, CODE_NUM=2, PULSE_NUM=4, REP_NUM=4, CHIP_LEN=2 -> MP pattern 11,10,11,10 per period, PRF_TICK every 8 cycles, PULSE_IDX runs 0..3.
REQ-045 SHALL verify clamping: CODE_NUM=40 with CODE_MAX=32 and PULSE_NUM=10 -> 32 coded chips, period 32 chips, no blank.
REQ-046 SHALL verify rejection: START with CHIP_LEN=0 -> CFG_ERR for one cycle, BUSY stays 0, MA stays 0.
REQ-047 SHALL verify ABORT at chip 5 of pulse 2 -> next cycle MA=0, BUSY=0, GEN_OVER=1, and a simultaneous START is ignored.
REQ-048 SHALL verify RESET mid-train -> reset values per REP-039 next cycle, and a new START is accepted normally.

Source files
------------

// File: rtl/pulse_code_pkg.sv
// Shared definitions for the pulse-code sequencer: state encoding and
// default widths used by the top level and its chip timer.
package pulse_code_pkg;

  localparam int CODE_MAX_DEF = 32;
  localparam int CHIP_W_DEF   = 16;
  localparam int REP_W_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN_CODE  = 2'd1,
    RUN_BLANK = 2'd2
  } state_t;

endpackage

// File: rtl/chip_timer.sv
// Loadable down-counter timing one chip; last is high on the final
// cycle of the chip (count zero).
module chip_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] cnt_q;

  // load_val is never zero here: a zero chip length is refused at START.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val - W'(1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign last = (cnt_q == '0);

endmodule

// File: rtl/pulse_code_seq.sv
// Coded pulse-train sequencer: emits REP_NUM periods of phase-coded chips
// followed by blank chips, with optional complementary code alternation.
module pulse_code_seq
  import pulse_code_pkg::*;
#(
  parameter int CODE_MAX = CODE_MAX_DEF,
  parameter int CHIP_W   = CHIP_W_DEF,
  parameter int REP_W    = REP_W_DEF
) (
  input  logic                CLOCK_10M,
  input  logic                RESET,
  input  logic                START,
  input  logic                ABORT,
  input  logic [CODE_MAX-1:0] CODE_A,
  input  logic [CODE_MAX-1:0] CODE_B,
  input  logic                ALT_EN,
  input  logic [7:0]          CODE_NUM,
  input  logic [15:0]         PULSE_NUM,
  input  logic [REP_W-1:0]    REP_NUM,
  input  logic [CHIP_W-1:0]   CHIP_LEN,
  output logic                MA,
  output logic                MP,
  output logic                PRF_TICK,
  output logic                BUSY,
  output logic                GEN_OVER,
  output logic                CFG_ERR,
  output logic [REP_W-1:0]    PULSE_IDX,
  output state_t              STATE_DBG
);

  localparam int IDX_W = (CODE_MAX > 1) ? $clog2(CODE_MAX) : 1;

  state_t              state_q, state_d;
  logic [CODE_MAX-1:0] code_a_q, code_b_q;
  logic                alt_q;
  logic [15:0]         code_len_q, period_q;
  logic [REP_W-1:0]    rep_q;
  logic [CHIP_W-1:0]   chip_len_q;
  logic [15:0]         chip_idx_q, chip_idx_d, chip_nxt;
  logic [REP_W-1:0]    pulse_idx_q, pulse_idx_d;

  logic [15:0]         code_len_in, period_in;
  logic                start_req, cfg_ok, accept, reject, running;
  logic                chip_last, period_end, train_end, timer_load;

  logic [CODE_MAX-1:0] code_a_e, code_b_e, code_sel;
  logic                alt_e;
  logic                ma_d, mp_d, prf_d, busy_d, cfg_err_d;

  assign code_len_in = ({8'd0, CODE_NUM} > 16'(CODE_MAX)) ? 16'(CODE_MAX) : {8'd0, CODE_NUM};
  assign period_in   = (PULSE_NUM > code_len_in) ? PULSE_NUM : code_len_in;

  assign start_req = (state_q == IDLE) && START && !ABORT;
  assign cfg_ok    = (CHIP_LEN != '0) && (REP_NUM != '0) && (period_in != '0);
  assign accept    = start_req && cfg_ok;
  assign reject    = start_req && !cfg_ok;
  assign running   = (state_q != IDLE);

  assign chip_nxt   = chip_idx_q + 16'd1;
  assign period_end = running && chip_last && (chip_idx_q == period_q - 16'd1);
  assign train_end  = period_end && (pulse_idx_q == rep_q - REP_W'(1));

  // Reload the timer at train start and at every chip boundary except the last.
  assign timer_load = accept || (running && !ABORT && chip_last && !train_end);

  chip_timer #(.W(CHIP_W)) u_chip_timer (
    .clk      (CLOCK_10M),
    .rst      (RESET),
    .clr      (ABORT),
    .load     (timer_load),
    .load_val (accept ? CHIP_LEN : chip_len_q),
    .last     (chip_last)
  );

  always_ff @(posedge CLOCK_10M) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    chip_idx_d  = chip_idx_q;
    pulse_idx_d = pulse_idx_q;
    if (accept) begin
      state_d     = (code_len_in == 16'd0) ? RUN_BLANK : RUN_CODE;
      chip_idx_d  = 16'd0;
      pulse_idx_d = '0;
    end else if (running) begin
      if (ABORT) begin
        state_d = IDLE;
      end else if (chip_last) begin
        if (train_end) begin
          state_d = IDLE;
        end else if (period_end) begin
          state_d     = (code_len_q == 16'd0) ? RUN_BLANK : RUN_CODE;
          chip_idx_d  = 16'd0;
          pulse_idx_d = pulse_idx_q + REP_W'(1);
        end else begin
          state_d    = (chip_nxt < code_len_q) ? RUN_CODE : RUN_BLANK;
          chip_idx_d = chip_nxt;
        end
      end
    end
  end

  // Outputs are computed for the upcoming cycle, so the first chip of a
  // freshly accepted train uses the live inputs rather than the latch.
  always_comb begin
    code_a_e  = accept ? CODE_A : code_a_q;
    code_b_e  = accept ? CODE_B : code_b_q;
    alt_e     = accept ? ALT_EN : alt_q;
    code_sel  = (alt_e && pulse_idx_d[0]) ? code_b_e : code_a_e;
    ma_d      = (state_d == RUN_CODE);
    mp_d      = ma_d && code_sel[chip_idx_d[IDX_W-1:0]];
    prf_d     = accept || (running && !ABORT && period_end && !train_end);
    busy_d    = (state_d != IDLE);
    cfg_err_d = reject;
  end

  always_ff @(posedge CLOCK_10M) begin
    if (RESET) begin
      code_a_q    <= '0;
      code_b_q    <= '0;
      alt_q       <= 1'b0;
      code_len_q  <= 16'd0;
      period_q    <= 16'd0;
      rep_q       <= '0;
      chip_len_q  <= '0;
      chip_idx_q  <= 16'd0;
      pulse_idx_q <= '0;
      MA          <= 1'b0;
      MP          <= 1'b0;
      PRF_TICK    <= 1'b0;
      BUSY        <= 1'b0;
      GEN_OVER    <= 1'b1;
      CFG_ERR     <= 1'b0;
    end else begin
      if (accept) begin
        code_a_q   <= CODE_A;
        code_b_q   <= CODE_B;
        alt_q      <= ALT_EN;
        code_len_q <= code_len_in;
        period_q   <= period_in;
        rep_q      <= REP_NUM;
        chip_len_q <= CHIP_LEN;
      end
      chip_idx_q  <= chip_idx_d;
      pulse_idx_q <= pulse_idx_d;
      MA          <= ma_d;
      MP          <= mp_d;
      PRF_TICK    <= prf_d;
      BUSY        <= busy_d;
      GEN_OVER    <= !busy_d;
      CFG_ERR     <= cfg_err_d;
    end
  end

  assign PULSE_IDX = pulse_idx_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_pulse_code_seq.sv
// Bench for pulse_code_seq: table of train configurations plus abort and
// reset sequences, checked cycle by cycle against a nested-loop chip model.
module tb_pulse_code_seq;
  import pulse_code_pkg::*;

  localparam int CODE_MAX = 32;
  localparam int CHIP_W   = 16;
  localparam int REP_W    = 16;
  localparam int OW       = 6 + REP_W;

  logic                CLOCK_10M = 1'b0;
  logic                RESET, START, ABORT, ALT_EN;
  logic [CODE_MAX-1:0] CODE_A, CODE_B;
  logic [7:0]          CODE_NUM;
  logic [15:0]         PULSE_NUM;
  logic [REP_W-1:0]    REP_NUM;
  logic [CHIP_W-1:0]   CHIP_LEN;
  logic                MA, MP, PRF_TICK, BUSY, GEN_OVER, CFG_ERR;
  logic [REP_W-1:0]    PULSE_IDX;
  state_t              STATE_DBG;

  always #50 CLOCK_10M = ~CLOCK_10M;

  pulse_code_seq #(.CODE_MAX(CODE_MAX), .CHIP_W(CHIP_W), .REP_W(REP_W)) dut (
    .CLOCK_10M (CLOCK_10M),
    .RESET     (RESET),
    .START     (START),
    .ABORT     (ABORT),
    .CODE_A    (CODE_A),
    .CODE_B    (CODE_B),
    .ALT_EN    (ALT_EN),
    .CODE_NUM  (CODE_NUM),
    .PULSE_NUM (PULSE_NUM),
    .REP_NUM   (REP_NUM),
    .CHIP_LEN  (CHIP_LEN),
    .MA        (MA),
    .MP        (MP),
    .PRF_TICK  (PRF_TICK),
    .BUSY      (BUSY),
    .GEN_OVER  (GEN_OVER),
    .CFG_ERR   (CFG_ERR),
    .PULSE_IDX (PULSE_IDX),
    .STATE_DBG (STATE_DBG)
  );

  typedef struct {
    string       name;
    logic [31:0] code_a;
    logic [31:0] code_b;
    logic        alt;
    int          code_num;
    int          pulse_num;
    int          rep;
    int          chip_len;
    logic        exp_ok;
    int          exp_cycles;
  } vec_t;

  vec_t             vecs[8];
  logic [OW-1:0]    exp_q[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  int               last_idx = 0;
  string            cur_name = "reset";

  function automatic vec_t mk(string n, logic [31:0] a, logic [31:0] b, logic alt,
                              int cn, int pn, int rp, int cl, logic ok, int cyc);
    vec_t v;
    v.name = n; v.code_a = a; v.code_b = b; v.alt = alt;
    v.code_num = cn; v.pulse_num = pn; v.rep = rp; v.chip_len = cl;
    v.exp_ok = ok; v.exp_cycles = cyc;
    return v;
  endfunction

  function automatic logic [OW-1:0] rec(logic ma, logic mp, logic prf, logic busy,
                                        logic over, logic err, int idx);
    return {ma, mp, prf, busy, over, err, REP_W'(idx)};
  endfunction

  task automatic check_one();
    logic [OW-1:0] e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {MA, MP, PRF_TICK, BUSY, GEN_OVER, CFG_ERR, PULSE_IDX};
      n_tests++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s @%0t: got ma=%b mp=%b prf=%b busy=%b over=%b err=%b idx=%0d, expected ma=%b mp=%b prf=%b busy=%b over=%b err=%b idx=%0d",
                 cur_name, $time, a[OW-1], a[OW-2], a[OW-3], a[OW-4], a[OW-5], a[OW-6], a[REP_W-1:0],
                 e[OW-1], e[OW-2], e[OW-3], e[OW-4], e[OW-5], e[OW-6], e[REP_W-1:0]);
      end
    end
  endtask

  // Inputs change on the falling edge; outputs are checked there too.
  task automatic step();
    @(posedge CLOCK_10M);
    @(negedge CLOCK_10M);
    check_one();
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() > 0 && guard < 100000) begin
      step();
      guard++;
    end
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: drain timeout, %0d expectations left, required 0", cur_name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic push_idle(int count);
    for (int i = 0; i < count; i++) exp_q.push_back(rec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, last_idx));
  endtask

  // Reference trace: pulses x chips x cycles; stops after 'limit' cycles.
  task automatic push_train(vec_t v, int limit);
    int len, per, n, full;
    logic [31:0] code;
    logic ma, mp;
    len  = (v.code_num > CODE_MAX) ? CODE_MAX : v.code_num;
    per  = (v.pulse_num > len) ? v.pulse_num : len;
    full = v.rep * per * v.chip_len;
    n = 0;
    for (int p = 0; p < v.rep; p++)
      for (int c = 0; c < per; c++)
        for (int k = 0; k < v.chip_len; k++) begin
          if (n < limit) begin
            code = (v.alt && (p % 2 == 1)) ? v.code_b : v.code_a;
            ma = (c < len);
            mp = ma ? code[c[4:0]] : 1'b0;
            exp_q.push_back(rec(ma, mp, (c == 0 && k == 0), 1'b1, 1'b0, 1'b0, p));
          end
          n++;
        end
    if (limit >= full) begin
      last_idx = v.rep - 1;
      push_idle(1);
    end
  endtask

  task automatic drive_cfg(vec_t v);
    CODE_A    = v.code_a;
    CODE_B    = v.code_b;
    ALT_EN    = v.alt;
    CODE_NUM  = 8'(v.code_num);
    PULSE_NUM = 16'(v.pulse_num);
    REP_NUM   = REP_W'(v.rep);
    CHIP_LEN  = CHIP_W'(v.chip_len);
  endtask

  task automatic scramble();
    CODE_A    = $urandom;
    CODE_B    = $urandom;
    ALT_EN    = 1'($urandom_range(0, 1));
    CODE_NUM  = 8'($urandom_range(0, 255));
    PULSE_NUM = 16'($urandom_range(0, 65535));
    REP_NUM   = REP_W'($urandom_range(0, 9));
    CHIP_LEN  = CHIP_W'($urandom_range(0, 9));
  endtask

  task automatic run_vec(vec_t v);
    cur_name = v.name;
    drive_cfg(v);
    START = 1'b1;
    if (v.exp_ok) begin
      push_train(v, v.exp_cycles);
    end else begin
      exp_q.push_back(rec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, last_idx));
      push_idle(1);
    end
    step();
    START = 1'b0;
    scramble();
    if (v.exp_ok) begin
      step();
      START = 1'b1;
      step();
      START = 1'b0;
    end
    drain();
    push_idle(2);
    drain();
  endtask

  initial begin
    vec_t v;
    vecs[0] = mk("nominal",    32'h0000BD1B, 32'h0, 1'b0, 16, 320, 1, 256, 1'b1, 81920);
    vecs[1] = mk("alternate",  32'h3,        32'h1, 1'b1,  2,   4, 4,   2, 1'b1, 32);
    vecs[2] = mk("clamp",      32'hA5C30F96, 32'h0, 1'b0, 40,  10, 1,   1, 1'b1, 32);
    vecs[3] = mk("rej_chip0",  32'h1,        32'h0, 1'b0,  4,   8, 2,   0, 1'b0, 0);
    vecs[4] = mk("rej_rep0",   32'hF,        32'h0, 1'b0,  4,   8, 0,   3, 1'b0, 0);
    vecs[5] = mk("rej_per0",   32'hF,        32'h0, 1'b0,  0,   0, 2,   3, 1'b0, 0);
    vecs[6] = mk("blank_only", 32'hF,        32'h0, 1'b0,  0,   3, 2,   1, 1'b1, 6);
    vecs[7] = mk("alt_chip1",  32'h5,        32'h2, 1'b1,  3,   7, 3,   1, 1'b1, 21);

    RESET = 1'b1; START = 1'b0; ABORT = 1'b0; ALT_EN = 1'b0;
    CODE_A = '0; CODE_B = '0; CODE_NUM = '0; PULSE_NUM = '0; REP_NUM = '0; CHIP_LEN = '0;
    step();
    push_idle(2);
    step();
    step();
    RESET = 1'b0;
    push_idle(2);
    drain();

    // Reorder so rejections follow a train that left PULSE_IDX at 3.
    run_vec(vecs[0]);
    run_vec(vecs[2]);
    run_vec(vecs[1]);
    for (int i = 3; i < 8; i++) run_vec(vecs[i]);
    run_vec(mk("code_gt_pulse", 32'h6, 32'h0, 1'b0, 3, 2, 2, 3, 1'b1, 18));

    // Abort during the first cycle of chip 5 of pulse 2, with START alongside.
    v = mk("abort", 32'h2D, 32'h13, 1'b1, 6, 8, 5, 2, 1'b1, 80);
    cur_name = v.name;
    drive_cfg(v);
    START = 1'b1;
    push_train(v, 43);
    step();
    START = 1'b0;
    repeat (42) step();
    ABORT = 1'b1;
    START = 1'b1;
    last_idx = 2;
    push_idle(1);
    step();
    ABORT = 1'b0;
    START = 1'b0;
    push_idle(2);
    drain();

    cur_name = "abort_start_idle";
    drive_cfg(vecs[1]);
    ABORT = 1'b1;
    START = 1'b1;
    push_idle(1);
    step();
    ABORT = 1'b0;
    START = 1'b0;
    push_idle(3);
    drain();

    // Reset in the middle of pulse 2, then a fresh train right after.
    cur_name = "reset_mid";
    drive_cfg(vecs[1]);
    START = 1'b1;
    push_train(vecs[1], 21);
    step();
    START = 1'b0;
    repeat (20) step();
    RESET = 1'b1;
    last_idx = 0;
    push_idle(1);
    step();
    RESET = 1'b0;
    run_vec(mk("after_reset", 32'h3, 32'h1, 1'b1, 2, 4, 4, 2, 1'b1, 32));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
